// File: rtl/da_dct_pkg.sv
// Shared types, default widths and the DCT odd-row coefficient set for the
// distributed-arithmetic DCT engine.
package da_dct_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEF_N_TAPS = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_N_ROWS = 4;

  localparam int COEF_ROWS = 4;
  localparam int COEF_TAPS = 4;

  // 0.5*c1, 0.5*c3, 0.5*c5, 0.5*c7 rows of the 8-point DCT, Q2.14
  localparam int COEF [COEF_ROWS][COEF_TAPS] = '{
    '{ 8035,  6811,  4551,  1598},
    '{ 6811, -1598, -8035, -4551},
    '{ 4551, -8035,  1598,  6811},
    '{ 1598, -4551,  6811, -8035}
  };

  // Coefficient lookup that reads as zero outside the stored table
  function automatic int coef_at(input int row, input int tap);
    if (row >= 0 && row < COEF_ROWS && tap >= 0 && tap < COEF_TAPS)
      return COEF[row][tap];
    return 0;
  endfunction

  // One DA table entry: sum of the row's coefficients over the set address bits
  function automatic int rom_entry(input int row, input int addr, input int n_taps);
    int sum;
    sum = 0;
    for (int k = 0; k < 32; k++) begin
      if (k < n_taps && addr[k])
        sum += coef_at(row, k);
    end
    return sum;
  endfunction

endpackage

// File: rtl/da_rom.sv
// Elaboration-time generated distributed-arithmetic lookup table, one
// 2^N_TAPS-entry slice per coefficient row; rows past N_ROWS read as zero.
module da_rom
  import da_dct_pkg::*;
#(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int ROW_W  = 2,
  parameter int ROM_W  = 18
) (
  input  logic        [ROW_W-1:0]  row,
  input  logic        [N_TAPS-1:0] addr,
  output logic signed [ROM_W-1:0]  data
);

  localparam int DEPTH = 2 ** N_TAPS;
  localparam logic [ROW_W:0] ROW_LIMIT = (ROW_W + 1)'(N_ROWS);

  logic signed [ROM_W-1:0] rom_tbl [N_ROWS][DEPTH];

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    for (genvar a = 0; a < DEPTH; a++) begin : g_addr
      assign rom_tbl[r][a] = ROM_W'(rom_entry(r, a, N_TAPS));
    end
  end

  // Table read; an unpopulated row decodes as all-zero coefficients
  always_comb begin
    data = '0;
    if ({1'b0, row} < ROW_LIMIT)
      data = rom_tbl[row][addr];
  end

endmodule

// File: rtl/da_dct_engine.sv
// Bit-serial distributed-arithmetic dot product of N_TAPS samples against one
// selectable coefficient row, one bit plane per cycle, MSB first.
module da_dct_engine
  import da_dct_pkg::*;
#(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int N_ROWS = DEF_N_ROWS,
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int ROM_W = COEF_W + $clog2(N_TAPS),
  localparam int ACC_W = ROM_W + DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_TAPS*DATA_W-1:0]   in_data,
  input  logic [ROW_W-1:0]           row_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    out_data,
  output logic                       busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

  state_t                   state;
  logic [DATA_W-1:0]        samples [N_TAPS];
  logic [ROW_W-1:0]         row_q;
  logic [CNT_W-1:0]         bit_cnt;
  logic signed [ACC_W-1:0]  acc;

  logic [N_TAPS-1:0]        plane;
  logic signed [ROM_W-1:0]  rom_data;
  logic signed [ACC_W-1:0]  rom_ext;

  // Gather the current bit plane across all captured samples as the ROM address
  always_comb begin
    plane = '0;
    for (int k = 0; k < N_TAPS; k++)
      plane[k] = samples[k][bit_cnt];
  end

  da_rom #(
    .N_TAPS (N_TAPS),
    .N_ROWS (N_ROWS),
    .ROW_W  (ROW_W),
    .ROM_W  (ROM_W)
  ) u_rom (
    .row  (row_q),
    .addr (plane),
    .data (rom_data)
  );

  assign rom_ext = {{DATA_W{rom_data[ROM_W-1]}}, rom_data};

  // Control FSM and shift-accumulate datapath; the MSB plane carries negative weight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row_q   <= '0;
      bit_cnt <= '0;
      acc     <= '0;
      for (int k = 0; k < N_TAPS; k++)
        samples[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N_TAPS; k++)
              samples[k] <= in_data[k*DATA_W +: DATA_W];
            row_q   <= row_sel;
            acc     <= '0;
            bit_cnt <= CNT_TOP;
            state   <= RUN;
          end
        end
        RUN: begin
          if (bit_cnt == CNT_TOP)
            acc <= -rom_ext;
          else
            acc <= (acc <<< 1) + rom_ext;
          if (bit_cnt == '0)
            state <= DONE;
          else
            bit_cnt <= bit_cnt - CNT_W'(1);
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = acc;

endmodule

// File: tb/tb_da_dct_engine.sv
// Self-checking bench for da_dct_engine: a default instance (4 rows) and a
// 3-row instance whose fourth row must read as zero coefficients.
module tb_da_dct_engine;

  localparam int ACC_W = 34;

  // Independent copy of the coefficient set used by the reference model
  localparam int C [4][4] = '{
    '{ 8035,  6811,  4551,  1598},
    '{ 6811, -1598, -8035, -4551},
    '{ 4551, -8035,  1598,  6811},
    '{ 1598, -4551,  6811, -8035}
  };

  logic clk;
  logic rst;

  logic                    in_valid  [2];
  logic                    in_ready  [2];
  logic [63:0]             in_data   [2];
  logic [1:0]              row_sel   [2];
  logic                    out_valid [2];
  logic                    out_ready [2];
  logic signed [ACC_W-1:0] out_data  [2];
  logic                    busy      [2];

  int total;
  int bad;
  logic signed [ACC_W-1:0] exp_q [$];

  da_dct_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .row_sel   (row_sel[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data[0]),
    .busy      (busy[0])
  );

  da_dct_engine #(.N_ROWS(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .row_sel   (row_sel[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data[1]),
    .busy      (busy[1])
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint model(input int nrows, input logic [63:0] vec, input int row);
    longint s;
    s = 0;
    if (row >= nrows) return 0;
    for (int k = 0; k < 4; k++)
      s += longint'($signed(vec[k*16 +: 16])) * longint'(C[row][k]);
    return s;
  endfunction

  // Push the expected value, hand one vector in, wait (bounded) for the result and score it
  task automatic run_vec(input int d, input logic [63:0] vec, input int row,
                         input longint expected, input bit check_lat, input bit scramble);
    int lat;
    logic signed [ACC_W-1:0] exp_v;
    exp_q.push_back(ACC_W'(expected));
    @(negedge clk);
    in_valid[d]  = 1'b1;
    in_data[d]   = vec;
    row_sel[d]   = 2'(row);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    if (scramble) begin
      in_data[d] = {$urandom, $urandom};
      row_sel[d] = 2'($urandom);
    end
    lat = 1;
    while (!out_valid[d] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_v = exp_q.pop_front();
    total++;
    if (!out_valid[d]) begin
      bad++;
      $display("[TB] FAIL result_timeout dut=%0d got no out_valid within %0d cycles, want %0d", d, lat, exp_v);
    end else if (out_data[d] !== exp_v) begin
      bad++;
      $display("[TB] FAIL result dut=%0d row=%0d vec=%h got %0d want %0d", d, row, vec, out_data[d], exp_v);
    end
    if (check_lat) begin
      total++;
      if (lat != 17) begin
        bad++;
        $display("[TB] FAIL latency got %0d want 17", lat);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; row_sel[d] = '0; out_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || out_data[d] !== '0) begin
        bad++;
        $display("[TB] FAIL reset_state dut=%0d got valid=%b busy=%b data=%0d want 0/0/0",
                 d, out_valid[d], busy[d], out_data[d]);
      end
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (in_ready[d] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL reset_in_ready dut=%0d got %b want 1", d, in_ready[d]);
      end
    end
  endtask

  task automatic test_basic();
    run_vec(0, 64'h0000_0000_0000_0001, 0, 8035, 1'b1, 1'b0);
    run_vec(0, 64'h0001_0001_0001_0001, 0, 20995, 1'b1, 1'b0);
    run_vec(0, 64'h0001_0001_0001_0001, 1, -7373, 1'b0, 1'b0);
    run_vec(0, 64'h0000_0000_0000_FFFF, 0, -8035, 1'b0, 1'b0);
    run_vec(0, 64'h8000_8000_8000_8000, 0, -64'sd687964160, 1'b0, 1'b0);
    run_vec(0, 64'h7FFF_7FFF_7FFF_7FFF, 3, 64'sd32767 * -64'sd4177, 1'b0, 1'b0);
    run_vec(1, 64'h0001_0001_0001_0001, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [63:0] v1, v2;
    int lat;
    logic signed [ACC_W-1:0] e1, e2;
    v1 = {16'sd7, 16'sd5, -16'sd2, 16'sd3};
    v2 = {-16'sd100, 16'sd250, 16'sd9, -16'sd4};
    exp_q.push_back(ACC_W'(model(4, v1, 2)));
    exp_q.push_back(ACC_W'(model(4, v2, 1)));
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = v1; row_sel[0] = 2'd2; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_data[0] = v2; row_sel[0] = 2'd1;
    lat = 1;
    while (!out_valid[0] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    e1 = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_data[0] !== e1) begin
        bad++;
        $display("[TB] FAIL hold cycle=%0d got valid=%b ready=%b data=%0d want 1/0/%0d",
                 i, out_valid[0], in_ready[0], out_data[0], e1);
      end
      @(posedge clk); #1;
    end
    @(negedge clk); out_ready[0] = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_handshake got ready=%b valid=%b busy=%b want 1/0/0",
               in_ready[0], out_valid[0], busy[0]);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 1;
    while (!out_valid[0] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    e2 = exp_q.pop_front();
    total++;
    if (!out_valid[0] || out_data[0] !== e2 || lat != 17) begin
      bad++;
      $display("[TB] FAIL second_vector got valid=%b data=%0d lat=%0d want 1/%0d/17",
               out_valid[0], out_data[0], lat, e2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 64'h1234_8765_0FF0_7ABC; row_sel[0] = 2'd0; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || out_data[0] !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset got valid=%b busy=%b data=%0d want 0/0/0",
               out_valid[0], busy[0], out_data[0]);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_recover got ready=%b valid=%b want 1/0", in_ready[0], out_valid[0]);
    end
    run_vec(0, 64'h0000_0000_0000_0001, 0, 8035, 1'b1, 1'b0);
  endtask

  task automatic test_input_change();
    logic [63:0] v;
    v = {-16'sd1234, 16'sd4321, -16'sd32768, 16'sd32767};
    run_vec(0, v, 3, model(4, v, 3), 1'b0, 1'b1);
    run_vec(1, v, 2, model(3, v, 2), 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [63:0] v;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 12; i++) begin
        v = {$urandom, $urandom};
        run_vec(d, v, i % 4, model(d == 0 ? 4 : 3, v, i % 4), 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_input_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
